// File: rtl/onoff_pkg.sv
// onoff_pkg: shared types and constants for the on/off channel bank.
//   chan_state_e : per-channel FSM state (ST_OFF, ST_ON, ST_LOCK)
//   DEB_W        : width of each debounce counter
package onoff_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_LOCK = 2'd2
  } chan_state_e;

  localparam int unsigned DEB_W = 16;

endpackage : onoff_pkg

// File: rtl/onoff_chan.sv
// onoff_chan: one independent on/off channel.
//   Two debounce filters (ON and OFF request), the channel FSM, an optional
//   ON-time timeout (ONOFF_BANK_TIMEOUT_EN) and registered edge pulses.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   sw_on/sw_off : raw (bouncing) ON / OFF requests
//   all_off      : synchronous global force-off, not debounced
//   on           : 1 while the channel is in ST_ON
//   on_next      : value 'on' takes after the next edge (for the bank counter)
//   on_pulse     : one cycle pulse in the first ON cycle
//   off_pulse    : one cycle pulse in the first cycle after leaving ST_ON
//   tmo_flag     : one cycle pulse when the timeout forced the channel off
module onoff_chan
  import onoff_pkg::*;
#(
  parameter int unsigned DEB_CNT = 8,
  parameter int unsigned TMO_CNT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_on,
  input  logic sw_off,
  input  logic all_off,
  output logic on,
  output logic on_next,
  output logic on_pulse,
  output logic off_pulse,
  output logic tmo_flag
);

  if (DEB_CNT < 1 || DEB_CNT > 65535 || TMO_CNT < 2 || TMO_CNT > 32'h00FF_FFFF) begin : g_param_err
    $error("onoff_chan: DEB_CNT or TMO_CNT out of range");
  end

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  // Bit 0 = ON request, bit 1 = OFF request.
  logic [1:0]            raw;
  logic [1:0]            filt_q, filt_d;
  logic [1:0][DEB_W-1:0] deb_q, deb_d;

  chan_state_e state_q, state_d;

  logic on_pulse_q, on_pulse_d;
  logic off_pulse_q, off_pulse_d;

  assign raw = {sw_off, sw_on};

  // Debounce: the counter runs only while raw differs from the filtered
  // value; the DEB_CNT-th consecutive differing sample updates the filter.
  always_comb begin
    filt_d = filt_q;
    deb_d  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (raw[i] != filt_q[i]) begin
        if (deb_q[i] == DEB_LAST) begin
          filt_d[i] = raw[i];
        end else begin
          deb_d[i] = deb_q[i] + DEB_W'(1);
        end
      end
    end
  end

`ifdef ONOFF_BANK_TIMEOUT_EN
  localparam int unsigned TMO_W = 24;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CNT - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TMO_LAST);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF: begin
        if (filt_q[0] && !filt_q[1] && !all_off) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (filt_q[1] || all_off) begin
          state_d = ST_OFF;
`ifdef ONOFF_BANK_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = ST_LOCK;
`endif
        end
      end
      ST_LOCK: begin
        // Held here until the ON switch is seen released, so a switch that
        // is still pressed cannot immediately re-enable the channel.
        if (!filt_q[0] || all_off) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    on_pulse_d  = (state_d == ST_ON) && (state_q != ST_ON);
    off_pulse_d = (state_q == ST_ON) && (state_d != ST_ON);
  end

`ifdef ONOFF_BANK_TIMEOUT_EN
  always_comb begin
    tmo_d      = tmo_q;
    tmo_flag_d = (state_q == ST_ON) && (state_d == ST_LOCK);
    if (state_q != ST_ON && state_d == ST_ON) begin
      tmo_d = '0;
    end else if (state_q == ST_ON && tmo_q != '1) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign tmo_flag = tmo_flag_q;
`else
  assign tmo_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q      <= '0;
      deb_q       <= '0;
      state_q     <= ST_OFF;
      on_pulse_q  <= 1'b0;
      off_pulse_q <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      deb_q       <= deb_d;
      state_q     <= state_d;
      on_pulse_q  <= on_pulse_d;
      off_pulse_q <= off_pulse_d;
    end
  end

  assign on        = (state_q == ST_ON);
  assign on_next   = (state_d == ST_ON);
  assign on_pulse  = on_pulse_q;
  assign off_pulse = off_pulse_q;

endmodule : onoff_chan

// File: rtl/onoff_bank.sv
// onoff_bank: CH independent debounced on/off channels plus an ON counter.
//   Optional per-channel ON timeout is built when ONOFF_BANK_TIMEOUT_EN is
//   defined; otherwise TMO_FLAG is constant 0 and TMO_CNT is unused.
// Ports:
//   CLK, RST_N        : clock, asynchronous active-low reset
//   SW_ON, SW_OFF     : raw per-channel ON / OFF requests (may bounce)
//   ALL_OFF           : synchronous force-off of every channel
//   ON                : per-channel ON level
//   ON_PULSE          : per-channel pulse in the first ON cycle
//   OFF_PULSE         : per-channel pulse in the first cycle after ON
//   TMO_FLAG          : per-channel pulse when switched off by timeout
//   ON_COUNT          : number of channels ON, aligned with ON
module onoff_bank #(
  parameter int unsigned CH      = 4,
  parameter int unsigned DEB_CNT = 8,
  parameter int unsigned TMO_CNT = 1000
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CH-1:0]             SW_ON,
  input  logic [CH-1:0]             SW_OFF,
  input  logic                      ALL_OFF,
  output logic [CH-1:0]             ON,
  output logic [CH-1:0]             ON_PULSE,
  output logic [CH-1:0]             OFF_PULSE,
  output logic [CH-1:0]             TMO_FLAG,
  output logic [$clog2(CH+1)-1:0]   ON_COUNT
);

  if (CH < 1 || CH > 32) begin : g_param_err
    $error("onoff_bank: CH out of range");
  end

  localparam int unsigned CNT_W = $clog2(CH + 1);

  logic [CH-1:0]    on_next;
  logic [CNT_W-1:0] on_count_q, on_count_d;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    onoff_chan #(
      .DEB_CNT (DEB_CNT),
      .TMO_CNT (TMO_CNT)
    ) u_chan (
      .clk       (CLK),
      .rst_n     (RST_N),
      .sw_on     (SW_ON[g]),
      .sw_off    (SW_OFF[g]),
      .all_off   (ALL_OFF),
      .on        (ON[g]),
      .on_next   (on_next[g]),
      .on_pulse  (ON_PULSE[g]),
      .off_pulse (OFF_PULSE[g]),
      .tmo_flag  (TMO_FLAG[g])
    );
  end

  // Counted from each channel's next state so the registered count lands
  // in the same cycle as the ON levels it describes.
  always_comb begin
    on_count_d = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      on_count_d = on_count_d + CNT_W'(on_next[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      on_count_q <= '0;
    end else begin
      on_count_q <= on_count_d;
    end
  end

  assign ON_COUNT = on_count_q;

endmodule : onoff_bank

// File: tb/tb_onoff_bank.sv
// tb_onoff_bank: directed + random stimulus against a behavioural model of
// the on/off bank (CH=4, DEB_CNT=4, TMO_CNT=10).
module tb_onoff_bank;

  localparam int unsigned CH  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 10;
  localparam int unsigned CW  = $clog2(CH + 1);
`ifdef ONOFF_BANK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] sw_on, sw_off;
  logic          all_off;
  logic [CH-1:0] on_o, on_pulse_o, off_pulse_o, tmo_flag_o;
  logic [CW-1:0] on_count_o;

  always #5 clk = ~clk;

  onoff_bank #(
    .CH      (CH),
    .DEB_CNT (DEB),
    .TMO_CNT (TMO)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .SW_ON     (sw_on),
    .SW_OFF    (sw_off),
    .ALL_OFF   (all_off),
    .ON        (on_o),
    .ON_PULSE  (on_pulse_o),
    .OFF_PULSE (off_pulse_o),
    .TMO_FLAG  (tmo_flag_o),
    .ON_COUNT  (on_count_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = off, 1 = on, 2 = locked out after timeout.
  int            mode   [CH];
  int            on_cyc [CH];
  bit            fon    [CH];
  bit            foff   [CH];
  logic [CH-1:0] on_hist[$];
  logic [CH-1:0] off_hist[$];

  logic [CH-1:0] exp_on, exp_onp, exp_offp, exp_tmo;
  logic [CW-1:0] exp_cnt;

  // True when the last DEB samples of channel c all equal 'want'.
  function automatic bit held_for(input logic [CH-1:0] h[$], input int c, input bit want);
    if (h.size() < DEB) return 1'b0;
    for (int k = 1; k <= DEB; k++) begin
      if (h[h.size() - k][c] !== want) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mode[c] = 0; on_cyc[c] = 0; fon[c] = 1'b0; foff[c] = 1'b0;
    end
    on_hist.delete();
    off_hist.delete();
    exp_on = '0; exp_onp = '0; exp_offp = '0; exp_tmo = '0; exp_cnt = '0;
  endtask

  task automatic model_edge(input logic [CH-1:0] son, input logic [CH-1:0] soff, input logic ao);
    int n;
    n = 0;
    for (int c = 0; c < CH; c++) begin
      int prev;
      prev = mode[c];
      case (prev)
        0: if (fon[c] && !foff[c] && !ao) begin mode[c] = 1; on_cyc[c] = 1; end
        1: begin
          if (foff[c] || ao) mode[c] = 0;
          else if (TMO_EN && on_cyc[c] == TMO) mode[c] = 2;
          else on_cyc[c]++;
        end
        default: if (!fon[c] || ao) mode[c] = 0;
      endcase
      exp_onp[c]  = (prev != 1) && (mode[c] == 1);
      exp_offp[c] = (prev == 1) && (mode[c] != 1);
      exp_tmo[c]  = (prev == 1) && (mode[c] == 2);
      exp_on[c]   = (mode[c] == 1);
      if (mode[c] == 1) n++;
    end
    exp_cnt = CW'(n);
    on_hist.push_back(son);
    off_hist.push_back(soff);
    while (on_hist.size() > DEB) void'(on_hist.pop_front());
    while (off_hist.size() > DEB) void'(off_hist.pop_front());
    for (int c = 0; c < CH; c++) begin
      if (held_for(on_hist, c, !fon[c])) fon[c] = !fon[c];
      if (held_for(off_hist, c, !foff[c])) foff[c] = !foff[c];
    end
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert (on_o === exp_on) else begin
      errors++; $error("FAIL %s ON got %b exp %b", tag, on_o, exp_on);
    end
    checks++;
    assert (on_pulse_o === exp_onp) else begin
      errors++; $error("FAIL %s ON_PULSE got %b exp %b", tag, on_pulse_o, exp_onp);
    end
    checks++;
    assert (off_pulse_o === exp_offp) else begin
      errors++; $error("FAIL %s OFF_PULSE got %b exp %b", tag, off_pulse_o, exp_offp);
    end
    checks++;
    assert (tmo_flag_o === exp_tmo) else begin
      errors++; $error("FAIL %s TMO_FLAG got %b exp %b", tag, tmo_flag_o, exp_tmo);
    end
    checks++;
    assert (on_count_o === exp_cnt) else begin
      errors++; $error("FAIL %s ON_COUNT got %0d exp %0d", tag, on_count_o, exp_cnt);
    end
  endtask

  task automatic step(input int n, input string tag);
    logic [CH-1:0] son, soff;
    logic          ao;
    for (int i = 0; i < n; i++) begin
      son = sw_on; soff = sw_off; ao = all_off;
      @(posedge clk);
      model_edge(son, soff, ao);
      #1;
      check_all(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; sw_on = '0; sw_off = '0; all_off = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Channel 0 held on; channel 1 bounces every 2 cycles and never settles.
    sw_on[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) sw_on[1] = ~sw_on[1];
      step(1, "deb_latency");
      if (i == 3) begin
        checks++;
        assert (on_o[0] === 1'b0) else begin
          errors++; $error("FAIL early_on0 got %b exp %b", on_o[0], 1'b0);
        end
      end
      if (i == 4) begin
        checks++;
        assert (on_o[0] === 1'b1 && on_pulse_o[0] === 1'b1 && on_count_o === CW'(1)) else begin
          errors++; $error("FAIL on0_at_edge4 got on=%b pulse=%b cnt=%0d exp 1 1 1",
                           on_o[0], on_pulse_o[0], on_count_o);
        end
      end
    end
    sw_on[1] = 1'b0;

    // ON and OFF both requested on channel 2: OFF wins.
    sw_on[2] = 1'b1; sw_off[2] = 1'b1;
    step(10, "on_off_both");
    checks++;
    assert (on_o[2] === 1'b0) else begin
      errors++; $error("FAIL on_off_both_ch2 got %b exp %b", on_o[2], 1'b0);
    end
    sw_on[2] = 1'b0; sw_off[2] = 1'b0;

    // Channel 0 held well past the timeout, released, then pressed again.
    step(12, "timeout_hold");
    sw_on[0] = 1'b0;
    step(6, "timeout_release");
    sw_on[0] = 1'b1;
    step(8, "timeout_repress");

    // All channels on, then a single-cycle ALL_OFF.
    sw_on = '1; sw_off = '0;
    step(6, "all_on");
    all_off = 1'b1;
    step(1, "all_off_pulse");
    all_off = 1'b0;
    step(3, "all_off_after");
    all_off = 1'b1;
    step(6, "all_off_held");
    all_off = 1'b0;
    sw_on = '0;
    step(8, "all_release");

    // Reset while channel 1 is three samples into its debounce.
    sw_on[1] = 1'b1;
    step(3, "pre_reset_deb");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst_n = 1'b1;
    step(6, "post_reset_deb");

    // Long hold: timeout behaviour (or its absence) over 50 cycles.
    sw_on = '0;
    sw_on[0] = 1'b1;
    step(50, "long_hold");
    sw_on = '0;
    step(6, "long_release");

    // Randomised switch activity with occasional ALL_OFF.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) sw_on[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) sw_off[$urandom_range(0, CH - 1)] ^= 1'b1;
      all_off = ($urandom_range(0, 39) == 0);
      step(1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_onoff_bank
